// File: rtl/audio_fifo_ctrl.sv
// audio_fifo_ctrl: 16-entry stereo sample FIFO controller around an external
// 16x8 dual-port SRAM. Port 1 of the SRAM is write-only and port 2 is read-only.
// The SRAM registers its read data, and that register serves as the output
// stage, so out_data is sram_o2 with no extra flop.
//
// Optional feature: define AUDIO_FIFO_CTRL_DROP_CNT_EN to add drop_cnt, a
// saturating count of cycles where an offered sample was refused.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid/in_data      upstream samples (even index = L, odd index = R)
//   in_ready              high while count < 16
//   out_valid/out_data    sample held in the SRAM read register
//   out_ch                0 = L, 1 = R (bit 0 of the read address)
//   out_ready             downstream accept
//   count, afull          occupancy not yet read, and count >= AFULL_THR
//   sram_*1               SRAM port 1 (write)
//   sram_*2, sram_o2      SRAM port 2 (read)
//   drop_cnt              refused-sample counter (optional)
module audio_fifo_ctrl #(
   parameter int unsigned AFULL_THR = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_ch,
   input  logic       out_ready,
   output logic [4:0] count,
   output logic       afull,
   output logic [3:0] sram_a1,
   output logic [7:0] sram_i1,
   output logic       sram_csb1,
   output logic       sram_web1,
   output logic       sram_oeb1,
   output logic [3:0] sram_a2,
   output logic       sram_csb2,
   output logic       sram_web2,
   output logic       sram_oeb2,
`ifdef AUDIO_FIFO_CTRL_DROP_CNT_EN
   output logic [7:0] drop_cnt,
`endif
   input  logic [7:0] sram_o2
);

   localparam int unsigned PTR_W = 4;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned DEPTH = 16;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             out_valid_q, out_valid_d;
   logic             out_ch_q, out_ch_d;
   logic             afull_q, afull_d;
   logic             in_ready_q, in_ready_d;
   logic             wr_en_c;
   logic             rd_en_c;

   // Write/read qualification; rst_n keeps both SRAM ports idle during reset
   always_comb begin
      wr_en_c = rst_n & in_valid & in_ready_q;
      rd_en_c = rst_n & (count_q != '0) & (~out_valid_q | out_ready);
   end

   // Next-state for pointers, occupancy and output-stage flags
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;

      if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({wr_en_c, rd_en_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A consume and a new issue in the same cycle keep out_valid high
      if (rd_en_c) begin
         out_valid_d = 1'b1;
         out_ch_d    = rd_ptr_q[0];
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // Flags are computed from the next count so they track count exactly
      afull_d    = (count_d >= CNT_W'(AFULL_THR));
      in_ready_d = (count_d < CNT_W'(DEPTH));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= 1'b0;
         afull_q     <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         afull_q     <= afull_d;
         in_ready_q  <= in_ready_d;
      end
   end

`ifdef AUDIO_FIFO_CTRL_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   // Saturating count of refused offers
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (in_valid && !in_ready_q && (drop_cnt_q != 8'hFF))
         drop_cnt_d = drop_cnt_q + 8'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

   // Status outputs
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign count     = count_q;
   assign afull     = afull_q;
   assign out_data  = sram_o2;

   // SRAM port 1: write-only
   assign sram_a1   = wr_ptr_q;
   assign sram_i1   = in_data;
   assign sram_csb1 = ~wr_en_c;
   assign sram_web1 = ~wr_en_c;
   assign sram_oeb1 = 1'b1;

   // SRAM port 2: read-only
   assign sram_a2   = rd_ptr_q;
   assign sram_csb2 = ~rd_en_c;
   assign sram_oeb2 = ~rd_en_c;
   assign sram_web2 = 1'b1;

endmodule

// File: tb/tb_audio_fifo_ctrl.sv
// Testbench for audio_fifo_ctrl: an SRAM model plus a queue-based reference
// model of the sample stream, driven with randomized and directed traffic.
module tb_audio_fifo_ctrl;

   localparam int unsigned THR = 12;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ch;
   logic       out_ready;
   logic [4:0] count;
   logic       afull;
   logic [3:0] sram_a1;
   logic [7:0] sram_i1;
   logic       sram_csb1, sram_web1, sram_oeb1;
   logic [3:0] sram_a2;
   logic       sram_csb2, sram_web2, sram_oeb2;
   logic [7:0] sram_o2;
`ifdef AUDIO_FIFO_CTRL_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int nchk = 0;
   int nerr = 0;

   audio_fifo_ctrl #(.AFULL_THR(THR)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready), .count(count), .afull(afull),
      .sram_a1(sram_a1), .sram_i1(sram_i1), .sram_csb1(sram_csb1),
      .sram_web1(sram_web1), .sram_oeb1(sram_oeb1),
      .sram_a2(sram_a2), .sram_csb2(sram_csb2), .sram_web2(sram_web2),
      .sram_oeb2(sram_oeb2),
`ifdef AUDIO_FIFO_CTRL_DROP_CNT_EN
      .drop_cnt(drop_cnt),
`endif
      .sram_o2(sram_o2)
   );

   always #5 clk = ~clk;

   // 16x8 dual-port SRAM with registered read data
   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (!sram_csb1 && !sram_web1) mem[sram_a1] <= sram_i1;
      if (!sram_csb2 && !sram_oeb2) sram_o2 <= mem[sram_a2];
   end

   // Reference model: samples stored but not yet read, plus one output slot
   logic [7:0] m_q [$];
   logic [7:0] consumed [$];
   logic       m_ov;
   logic [7:0] m_data;
   logic       m_ch;
   int         m_rd_idx;
   int         m_drops;

   task automatic model_reset();
      m_q.delete();
      consumed.delete();
      m_ov = 1'b0; m_data = '0; m_ch = 1'b0; m_rd_idx = 0; m_drops = 0;
   endtask

   // One clock of stimulus; applies the stream rules to the model
   task automatic step(input logic iv, input logic [7:0] id, input logic ordy);
      logic wr, rd;
      in_valid = iv; in_data = id; out_ready = ordy;
      wr = iv && (m_q.size() < 16);
      rd = (m_q.size() > 0) && (!m_ov || ordy);
      if (iv && !wr && m_drops < 255) m_drops++;
      if (m_ov && ordy) consumed.push_back(m_data);
      @(posedge clk);
      if (rd) begin
         m_data = m_q.pop_front();
         m_ov = 1'b1;
         m_ch = m_rd_idx[0];
         m_rd_idx++;
      end else if (m_ov && ordy) begin
         m_ov = 1'b0;
      end
      if (wr) m_q.push_back(id);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
      model_reset();
      #12;
      nchk++;
      if ({count, out_valid, in_ready, afull, sram_csb1, sram_csb2} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
         nerr++;
         $display("FAIL reset_state: got cnt=%0d ov=%b ir=%b af=%b csb1=%b csb2=%b, need 0 0 1 0 1 1",
                  count, out_valid, in_ready, afull, sram_csb1, sram_csb2);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      nchk++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL reset_release: got ir=%b ov=%b, need 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_single();
      step(1'b1, 8'h5A, 1'b1);
      nchk++;
      if (count !== 5'd1 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL single_accept: got cnt=%0d ov=%b, need 1 0", count, out_valid);
      end
      step(1'b0, 8'h00, 1'b1);
      nchk++;
      if ({out_valid, out_data, out_ch, count} !== {1'b1, 8'h5A, 1'b0, 5'd0}) begin
         nerr++;
         $display("FAIL single_out: got ov=%b d=%h ch=%b cnt=%0d, need 1 5a 0 0",
                  out_valid, out_data, out_ch, count);
      end
      step(1'b0, 8'h00, 1'b1);
      nchk++;
      if (out_valid !== 1'b0 || consumed.size() != 1) begin
         nerr++;
         $display("FAIL single_done: got ov=%b consumed=%0d, need 0 1", out_valid, consumed.size());
      end
   endtask

   // Output register holds one sample, so 17 are accepted before in_ready drops
   task automatic test_fill();
      for (int i = 0; i < 18; i++) begin
         step(1'b1, 8'(i), 1'b0);
         nchk++;
         if ({count, in_ready, out_valid, afull} !== {5'(m_q.size()), m_q.size() < 16, m_ov, m_q.size() >= THR}) begin
            nerr++;
            $display("FAIL fill_status[%0d]: got cnt=%0d ir=%b ov=%b af=%b, need %0d %b %b %b", i,
                     count, in_ready, out_valid, afull, m_q.size(), m_q.size() < 16, m_ov, m_q.size() >= THR);
         end
      end
      nchk++;
      if ({count, in_ready, afull, out_data} !== {5'd16, 1'b0, 1'b1, 8'h00}) begin
         nerr++;
         $display("FAIL fill_full: got cnt=%0d ir=%b af=%b d=%h, need 16 0 1 00", count, in_ready, afull, out_data);
      end
`ifdef AUDIO_FIFO_CTRL_DROP_CNT_EN
      nchk++;
      if (drop_cnt !== 8'(m_drops)) begin
         nerr++;
         $display("FAIL fill_drop_cnt: got %0d, need %0d", drop_cnt, m_drops);
      end
`endif
   endtask

   task automatic test_drain();
      for (int i = 0; i < 18; i++) begin
         step(1'b0, 8'h00, 1'b1);
         nchk++;
         if ({count, out_valid, afull} !== {5'(m_q.size()), m_ov, m_q.size() >= THR}) begin
            nerr++;
            $display("FAIL drain_status[%0d]: got cnt=%0d ov=%b af=%b, need %0d %b %b", i,
                     count, out_valid, afull, m_q.size(), m_ov, m_q.size() >= THR);
         end
         if (m_ov) begin
            nchk++;
            if ({out_data, out_ch} !== {m_data, m_ch}) begin
               nerr++;
               $display("FAIL drain_data[%0d]: got d=%h ch=%b, need d=%h ch=%b", i, out_data, out_ch, m_data, m_ch);
            end
         end
      end
      nchk++;
      if (count !== 5'd0 || consumed.size() != 18) begin
         nerr++;
         $display("FAIL drain_end: got cnt=%0d consumed=%0d, need 0 18", count, consumed.size());
      end
   endtask

   task automatic test_wrap();
      int max_cnt = 0;
      for (int i = 0; i < 43; i++) begin
         step(i < 40, 8'($urandom), 1'b1);
         if (int'(count) > max_cnt) max_cnt = int'(count);
         nchk++;
         if ({count, out_valid} !== {5'(m_q.size()), m_ov}) begin
            nerr++;
            $display("FAIL wrap_status[%0d]: got cnt=%0d ov=%b, need %0d %b", i, count, out_valid, m_q.size(), m_ov);
         end
         if (m_ov) begin
            nchk++;
            if ({out_data, out_ch} !== {m_data, m_ch}) begin
               nerr++;
               $display("FAIL wrap_data[%0d]: got d=%h ch=%b, need d=%h ch=%b", i, out_data, out_ch, m_data, m_ch);
            end
         end
      end
      nchk++;
      if (max_cnt > 2) begin
         nerr++;
         $display("FAIL wrap_max_count: got %0d, need <= 2", max_cnt);
      end
   endtask

   task automatic test_backpressure();
      int   sent = 0;
      logic [7:0] prev_d;
      logic prev_stall = 1'b0;
      consumed.delete();
      for (int i = 0; i < 300 && (sent < 16 || m_ov || m_q.size() > 0); i++) begin
         logic iv, ordy;
         iv = (sent < 16) && ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 1) != 0);
         prev_stall = out_valid && !ordy;
         prev_d = out_data;
         if (iv && m_q.size() < 16) begin
            step(1'b1, 8'(8'h10 + sent), ordy);
            sent++;
         end else begin
            step(iv, 8'(8'h10 + sent), ordy);
         end
         nchk++;
         if ({count, in_ready, out_valid, afull} !== {5'(m_q.size()), m_q.size() < 16, m_ov, m_q.size() >= THR}) begin
            nerr++;
            $display("FAIL bp_status[%0d]: got cnt=%0d ir=%b ov=%b af=%b, need %0d %b %b %b", i,
                     count, in_ready, out_valid, afull, m_q.size(), m_q.size() < 16, m_ov, m_q.size() >= THR);
         end
         if (m_ov) begin
            nchk++;
            if ({out_data, out_ch} !== {m_data, m_ch}) begin
               nerr++;
               $display("FAIL bp_data[%0d]: got d=%h ch=%b, need d=%h ch=%b", i, out_data, out_ch, m_data, m_ch);
            end
         end
         if (prev_stall) begin
            nchk++;
            if (out_data !== prev_d) begin
               nerr++;
               $display("FAIL bp_stable[%0d]: got d=%h, need held %h", i, out_data, prev_d);
            end
         end
      end
      nchk++;
      if (consumed.size() != 16) begin
         nerr++;
         $display("FAIL bp_total: got %0d samples, need 16", consumed.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            nchk++;
            if (consumed[k] !== 8'(8'h10 + k)) begin
               nerr++;
               $display("FAIL bp_order[%0d]: got %h, need %h", k, consumed[k], 8'(8'h10 + k));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 20 && m_q.size() < 7; i++)
         step(1'b1, 8'($urandom), 1'b0);
      nchk++;
      if (count !== 5'd7 || out_valid !== 1'b1) begin
         nerr++;
         $display("FAIL rmid_pre: got cnt=%0d ov=%b, need 7 1", count, out_valid);
      end
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      nchk++;
      if ({count, out_valid, in_ready, afull, sram_csb1, sram_csb2} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
         nerr++;
         $display("FAIL rmid_async: got cnt=%0d ov=%b ir=%b af=%b csb1=%b csb2=%b, need 0 0 1 0 1 1",
                  count, out_valid, in_ready, afull, sram_csb1, sram_csb2);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00, 1'b1);
         nchk++;
         if ({count, out_valid, in_ready} !== {5'd0, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL rmid_idle[%0d]: got cnt=%0d ov=%b ir=%b, need 0 0 1", i, count, out_valid, in_ready);
         end
      end
      // Fresh traffic after reset restarts at the L channel
      step(1'b1, 8'hC3, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      nchk++;
      if ({out_valid, out_data, out_ch} !== {1'b1, 8'hC3, 1'b0}) begin
         nerr++;
         $display("FAIL rmid_after: got ov=%b d=%h ch=%b, need 1 c3 0", out_valid, out_data, out_ch);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_drain();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
